// File: rtl/micro_udp_engine_pkg.sv
// Shared types and constants for the micro UDP engine TX path.
package micro_udp_engine_pkg;

  localparam int unsigned DATA_W_DEF = 256;

  // Width of the empty-byte count for a given data bus width.
  function automatic int unsigned empty_w(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

endpackage

// File: rtl/micro_udp_engine_pipe_reg.sv
// Single output register stage with valid/ready hold behaviour.
module micro_udp_engine_pipe_reg #(
  parameter int unsigned DATA_W  = 256,
  parameter int unsigned EMPTY_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_ready,
  input  logic [DATA_W-1:0]  i_data,
  input  logic [EMPTY_W-1:0] i_empty,
  input  logic               i_sop,
  input  logic               i_eop,
  output logic               o_valid,
  output logic [DATA_W-1:0]  o_data,
  output logic [EMPTY_W-1:0] o_empty,
  output logic               o_sop,
  output logic               o_eop
);

  logic               r_valid;
  logic [DATA_W-1:0]  r_data;
  logic [EMPTY_W-1:0] r_empty;
  logic               r_sop;
  logic               r_eop;

  // Load a new beat when offered; otherwise hold until the sink accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_empty <= '0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_empty <= i_empty;
      r_sop   <= i_sop;
      r_eop   <= i_eop;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_empty = r_empty;
  assign o_sop   = r_sop;
  assign o_eop   = r_eop;

endmodule

// File: rtl/micro_udp_engine_tx_arb.sv
// Packet-atomic round-robin arbiter merging NUM_CH TX sources onto one MAC stream.
module micro_udp_engine_tx_arb
  import micro_udp_engine_pkg::*;
#(
  parameter  int unsigned NUM_CH  = 3,
  parameter  int unsigned DATA_W  = DATA_W_DEF,
  parameter  int unsigned CNT_W   = 32,
  localparam int unsigned EMPTY_W = empty_w(DATA_W),
  localparam int unsigned CH_W    = $clog2(NUM_CH)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_CH*DATA_W-1:0]  in_data,
  input  logic [NUM_CH*EMPTY_W-1:0] in_empty,
  input  logic [NUM_CH-1:0]         in_startofpacket,
  input  logic [NUM_CH-1:0]         in_endofpacket,
  input  logic [NUM_CH-1:0]         in_valid,
  output logic [NUM_CH-1:0]         in_ready,
  output logic [DATA_W-1:0]         l4_tx_data,
  output logic [EMPTY_W-1:0]        l4_tx_empty,
  output logic                      l4_tx_startofpacket,
  output logic                      l4_tx_endofpacket,
  output logic                      l4_tx_valid,
  input  logic                      l4_tx_ready,
  output logic [NUM_CH*CNT_W-1:0]   pkt_cnt,
  output logic [NUM_CH*CNT_W-1:0]   err_cnt,
  output logic [CH_W-1:0]           cur_grant
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;

  logic [CH_W-1:0]               r_cur_grant;
  logic                          r_granted;
  logic [CH_W-1:0]               w_gnt_ch;
  logic                          w_gnt_vld;
  logic                          w_pipe_rdy;
  logic                          w_fwd;
  logic                          w_sel_valid;
  logic                          w_sel_sop;
  logic                          w_sel_eop;
  logic [DATA_W-1:0]             w_sel_data;
  logic [EMPTY_W-1:0]            w_sel_empty;
  logic [NUM_CH-1:0]             w_orphan;
  logic [NUM_CH-1:0][CNT_W-1:0]  r_pkt_cnt;
  logic [NUM_CH-1:0][CNT_W-1:0]  r_err_cnt;
  logic [NUM_CH-1:0][CNT_W-1:0]  w_pkt_cnt_nxt;
  logic [NUM_CH-1:0][CNT_W-1:0]  w_err_cnt_nxt;

  // Grant selection: locked channel in LOCK, round-robin SOP search in IDLE.
  // Before the first grant after reset the search starts at channel 0.
  always_comb begin
    int unsigned v_start;
    int unsigned v_idx;
    w_gnt_vld = 1'b0;
    w_gnt_ch  = r_cur_grant;
    v_start   = r_granted ? (32'(r_cur_grant) + 32'd1) : 32'd0;
    v_idx     = 32'd0;
    if (r_state == LOCK) begin
      w_gnt_vld = 1'b1;
    end else begin
      for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
        v_idx = (v_start + 32'(i)) % NUM_CH;
        if (in_valid[CH_W'(v_idx)] && in_startofpacket[CH_W'(v_idx)]) begin
          w_gnt_vld = 1'b1;
          w_gnt_ch  = CH_W'(v_idx);
        end
      end
    end
  end

  // Mux the granted channel's beat.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_sop   = 1'b0;
    w_sel_eop   = 1'b0;
    w_sel_data  = '0;
    w_sel_empty = '0;
    for (int ch = 0; ch < int'(NUM_CH); ch++) begin
      if (CH_W'(ch) == w_gnt_ch) begin
        w_sel_valid = in_valid[ch];
        w_sel_sop   = in_startofpacket[ch];
        w_sel_eop   = in_endofpacket[ch];
        w_sel_data  = in_data[ch*DATA_W +: DATA_W];
        w_sel_empty = in_empty[ch*EMPTY_W +: EMPTY_W];
      end
    end
  end

  // Per-channel ready: granted channel follows the output stage, orphans are sunk in IDLE.
  always_comb begin
    in_ready   = '0;
    w_orphan   = '0;
    w_pipe_rdy = l4_tx_ready | ~l4_tx_valid;
    for (int ch = 0; ch < int'(NUM_CH); ch++) begin
      if (r_state == IDLE) begin
        w_orphan[ch] = in_valid[ch] & ~in_startofpacket[ch];
      end
      if (w_gnt_vld && (CH_W'(ch) == w_gnt_ch)) begin
        in_ready[ch] = reset_n & w_pipe_rdy;
      end else begin
        in_ready[ch] = reset_n & w_orphan[ch];
      end
    end
  end

  assign w_fwd = w_gnt_vld & w_sel_valid & w_pipe_rdy;

  // Arbiter next-state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_fwd && !w_sel_eop) w_state_nxt = LOCK;
      LOCK:    if (w_fwd && w_sel_eop)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Counter next values; both wrap naturally at CNT_W bits.
  always_comb begin
    w_pkt_cnt_nxt = r_pkt_cnt;
    w_err_cnt_nxt = r_err_cnt;
    for (int ch = 0; ch < int'(NUM_CH); ch++) begin
      w_pkt_cnt_nxt[ch] = r_pkt_cnt[ch] +
                          CNT_W'(w_fwd && w_sel_eop && (w_gnt_ch == CH_W'(ch)));
      w_err_cnt_nxt[ch] = r_err_cnt[ch] + CNT_W'(w_orphan[ch]);
    end
  end

  // Arbiter state, grant history and counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cur_grant <= '0;
      r_granted   <= 1'b0;
      r_pkt_cnt   <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pkt_cnt <= w_pkt_cnt_nxt;
      r_err_cnt <= w_err_cnt_nxt;
      if ((r_state == IDLE) && w_fwd) begin
        r_cur_grant <= w_gnt_ch;
        r_granted   <= 1'b1;
      end
    end
  end

  micro_udp_engine_pipe_reg #(
    .DATA_W  (DATA_W),
    .EMPTY_W (EMPTY_W)
  ) u_pipe_reg (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_load  (w_fwd),
    .i_ready (l4_tx_ready),
    .i_data  (w_sel_data),
    .i_empty (w_sel_empty),
    .i_sop   (w_sel_sop),
    .i_eop   (w_sel_eop),
    .o_valid (l4_tx_valid),
    .o_data  (l4_tx_data),
    .o_empty (l4_tx_empty),
    .o_sop   (l4_tx_startofpacket),
    .o_eop   (l4_tx_endofpacket)
  );

  assign pkt_cnt   = r_pkt_cnt;
  assign err_cnt   = r_err_cnt;
  assign cur_grant = r_cur_grant;

endmodule

// File: tb/tb_micro_udp_engine_tx_arb.sv
// Directed bench for the TX arbiter: source queues, scoreboard, counter checks.
module tb_micro_udp_engine_tx_arb;

  localparam int unsigned NUM_CH  = 3;
  localparam int unsigned DATA_W  = 256;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned EMPTY_W = 5;
  localparam int unsigned CH_W    = 2;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [EMPTY_W-1:0] empty;
    logic               sop;
    logic               eop;
  } beat_t;

  logic                      clk = 1'b0;
  logic                      reset_n = 1'b0;
  logic [NUM_CH*DATA_W-1:0]  in_data = '0;
  logic [NUM_CH*EMPTY_W-1:0] in_empty = '0;
  logic [NUM_CH-1:0]         in_startofpacket = '0;
  logic [NUM_CH-1:0]         in_endofpacket = '0;
  logic [NUM_CH-1:0]         in_valid = '0;
  logic [NUM_CH-1:0]         in_ready;
  logic [DATA_W-1:0]         l4_tx_data;
  logic [EMPTY_W-1:0]        l4_tx_empty;
  logic                      l4_tx_startofpacket;
  logic                      l4_tx_endofpacket;
  logic                      l4_tx_valid;
  logic                      l4_tx_ready = 1'b1;
  logic [NUM_CH*CNT_W-1:0]   pkt_cnt;
  logic [NUM_CH*CNT_W-1:0]   err_cnt;
  logic [CH_W-1:0]           cur_grant;

  int    n_cmp = 0;
  int    n_bad = 0;
  bit    rdy_toggle = 1'b0;
  int    xfer_cnt [NUM_CH];
  beat_t src_q [NUM_CH][$];
  beat_t exp_q [$];

  micro_udp_engine_tx_arb #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .in_data             (in_data),
    .in_empty            (in_empty),
    .in_startofpacket    (in_startofpacket),
    .in_endofpacket      (in_endofpacket),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .l4_tx_data          (l4_tx_data),
    .l4_tx_empty         (l4_tx_empty),
    .l4_tx_startofpacket (l4_tx_startofpacket),
    .l4_tx_endofpacket   (l4_tx_endofpacket),
    .l4_tx_valid         (l4_tx_valid),
    .l4_tx_ready         (l4_tx_ready),
    .pkt_cnt             (pkt_cnt),
    .err_cnt             (err_cnt),
    .cur_grant           (cur_grant)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CNT_W-1:0] pkt_of(input int ch);
    return pkt_cnt[ch*CNT_W +: CNT_W];
  endfunction

  function automatic logic [CNT_W-1:0] err_of(input int ch);
    return err_cnt[ch*CNT_W +: CNT_W];
  endfunction

  function automatic beat_t mk_beat(input int ch, input int pkt, input int idx, input bit sop, input bit eop);
    beat_t b;
    for (int w = 0; w < int'(DATA_W / 32); w++) begin
      b.data[w*32 +: 32] = {8'(ch), 8'(pkt), 8'(idx), 8'(w)};
    end
    b.empty = EMPTY_W'(ch * 7 + idx);
    b.sop   = sop;
    b.eop   = eop;
    return b;
  endfunction

  // Queue a packet at a source; the call order is the hand-computed output order.
  task automatic push_pkt(input int ch, input int pkt, input int nbeats);
    beat_t b;
    for (int i = 0; i < nbeats; i++) begin
      b = mk_beat(ch, pkt, i, i == 0, i == nbeats - 1);
      src_q[ch].push_back(b);
      exp_q.push_back(b);
    end
  endtask

  // Queue a beat without SOP; it is expected to be dropped.
  task automatic push_orphan(input int ch);
    src_q[ch].push_back(mk_beat(ch, 99, 5, 1'b0, 1'b0));
  endtask

  task automatic drive_inputs();
    beat_t b;
    for (int ch = 0; ch < int'(NUM_CH); ch++) begin
      if (src_q[ch].size() > 0) begin
        b = src_q[ch][0];
        in_valid[ch]                       = 1'b1;
        in_data[ch*DATA_W +: DATA_W]       = b.data;
        in_empty[ch*EMPTY_W +: EMPTY_W]    = b.empty;
        in_startofpacket[ch]               = b.sop;
        in_endofpacket[ch]                 = b.eop;
      end else begin
        in_valid[ch]                       = 1'b0;
        in_data[ch*DATA_W +: DATA_W]       = '0;
        in_empty[ch*EMPTY_W +: EMPTY_W]    = '0;
        in_startofpacket[ch]               = 1'b0;
        in_endofpacket[ch]                 = 1'b0;
      end
    end
  endtask

  // One clock: score the output at negedge, then advance sources after the edge.
  task automatic tick();
    bit              out_acc;
    bit [NUM_CH-1:0] acc;
    @(negedge clk);
    if (l4_tx_valid) begin
      if (exp_q.size() == 0) check_val("extra_beat", 512'(1), 512'(0));
      else check_val("out_beat",
                     512'({l4_tx_data, l4_tx_empty, l4_tx_startofpacket, l4_tx_endofpacket}),
                     512'(exp_q[0]));
    end
    out_acc = l4_tx_valid && l4_tx_ready && (exp_q.size() > 0);
    acc     = in_valid & in_ready;
    @(posedge clk);
    #1;
    if (out_acc) void'(exp_q.pop_front());
    for (int ch = 0; ch < int'(NUM_CH); ch++) begin
      if (acc[ch]) begin
        void'(src_q[ch].pop_front());
        xfer_cnt[ch]++;
      end
    end
    if (rdy_toggle) l4_tx_ready = ~l4_tx_ready;
    drive_inputs();
  endtask

  function automatic bit all_done();
    for (int ch = 0; ch < int'(NUM_CH); ch++) begin
      if (src_q[ch].size() != 0) return 1'b0;
    end
    return (exp_q.size() == 0) && !l4_tx_valid;
  endfunction

  task automatic drain(input int max_cyc);
    int n = 0;
    while (!all_done() && n < max_cyc) begin
      tick();
      n++;
    end
    if (!all_done()) check_val("drain_timeout", 512'(0), 512'(1));
  endtask

  task automatic clear_all();
    for (int ch = 0; ch < int'(NUM_CH); ch++) begin
      src_q[ch].delete();
      xfer_cnt[ch] = 0;
    end
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    rdy_toggle  = 1'b0;
    l4_tx_ready = 1'b1;
    clear_all();
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    // Reset state, with every channel offering an SOP beat.
    reset_n          = 1'b0;
    in_valid         = '1;
    in_startofpacket = '1;
    @(negedge clk);
    check_val("rst_in_ready",  512'(in_ready), 512'(0));
    check_val("rst_valid",     512'(l4_tx_valid), 512'(0));
    check_val("rst_data",      512'(l4_tx_data), 512'(0));
    check_val("rst_flags",     512'({l4_tx_empty, l4_tx_startofpacket, l4_tx_endofpacket}), 512'(0));
    check_val("rst_pkt_cnt",   512'(pkt_cnt), 512'(0));
    check_val("rst_err_cnt",   512'(err_cnt), 512'(0));
    check_val("rst_cur_grant", 512'(cur_grant), 512'(0));

    // ch0 3-beat and ch1 1-beat presented together: ch0 first, then ch1.
    do_reset();
    push_pkt(0, 1, 3);
    push_pkt(1, 1, 1);
    drive_inputs();
    #1;
    check_val("t1_ready_ch0", 512'(in_ready), 512'(3'b001));
    check_val("t1_valid_pre", 512'(l4_tx_valid), 512'(0));
    tick();
    check_val("t1_valid_lat", 512'(l4_tx_valid), 512'(1));
    check_val("t1_sop_lat",   512'(l4_tx_startofpacket), 512'(1));
    check_val("t1_ready_lock", 512'(in_ready), 512'(3'b001));
    drain(50);
    check_val("t1_pkt0",  512'(pkt_of(0)), 512'(1));
    check_val("t1_pkt1",  512'(pkt_of(1)), 512'(1));
    check_val("t1_grant", 512'(cur_grant), 512'(1));
    check_val("t1_err",   512'(err_cnt), 512'(0));

    // Three channels continuously offering 2-beat packets: grants 0,1,2,0,...
    do_reset();
    for (int p = 0; p < 4; p++) begin
      for (int ch = 0; ch < int'(NUM_CH); ch++) push_pkt(ch, p, 2);
    end
    drive_inputs();
    drain(100);
    for (int ch = 0; ch < int'(NUM_CH); ch++) begin
      check_val("t2_pkt", 512'(pkt_of(ch)), 512'(4));
    end
    check_val("t2_grant", 512'(cur_grant), 512'(2));

    // 4-beat packet with l4_tx_ready toggling: scoreboard also checks stalled cycles.
    do_reset();
    rdy_toggle = 1'b1;
    push_pkt(0, 7, 4);
    drive_inputs();
    drain(100);
    rdy_toggle  = 1'b0;
    l4_tx_ready = 1'b1;
    check_val("t3_pkt0", 512'(pkt_of(0)), 512'(1));
    check_val("t3_xfer", 512'(xfer_cnt[0]), 512'(4));

    // Orphan on ch2 while IDLE is sunk and counted, nothing is forwarded.
    do_reset();
    push_orphan(2);
    drive_inputs();
    #1;
    check_val("t4_ready_orphan", 512'(in_ready), 512'(3'b100));
    drain(20);
    check_val("t4_err2", 512'(err_of(2)), 512'(1));
    check_val("t4_pkt",  512'(pkt_cnt), 512'(0));
    // Granted SOP on ch0 and orphan on ch1 in the same cycle.
    push_pkt(0, 3, 1);
    push_orphan(1);
    drive_inputs();
    #1;
    check_val("t4_ready_both", 512'(in_ready), 512'(3'b011));
    drain(20);
    check_val("t4_err1", 512'(err_of(1)), 512'(1));
    check_val("t4_pkt0", 512'(pkt_of(0)), 512'(1));
    check_val("t4_err2_hold", 512'(err_of(2)), 512'(1));

    // Reset after beat 2 of a ch1 packet, then a fresh packet is forwarded intact.
    do_reset();
    push_pkt(1, 4, 4);
    drive_inputs();
    begin
      int n = 0;
      while (xfer_cnt[1] < 2 && n < 20) begin
        tick();
        n++;
      end
    end
    check_val("t5_two_beats", 512'(xfer_cnt[1]), 512'(2));
    check_val("t5_grant_pre", 512'(cur_grant), 512'(1));
    reset_n = 1'b0;
    @(negedge clk);
    check_val("t5_rst_valid", 512'(l4_tx_valid), 512'(0));
    check_val("t5_rst_out",   512'({l4_tx_data, l4_tx_empty, l4_tx_startofpacket, l4_tx_endofpacket}), 512'(0));
    check_val("t5_rst_ready", 512'(in_ready), 512'(0));
    check_val("t5_rst_grant", 512'(cur_grant), 512'(0));
    clear_all();
    drive_inputs();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    push_pkt(1, 9, 4);
    drive_inputs();
    drain(50);
    check_val("t5_pkt1", 512'(pkt_of(1)), 512'(1));
    check_val("t5_err",  512'(err_cnt), 512'(0));

    // Counters preloaded to all-ones wrap to zero on the next packet.
    do_reset();
    force dut.r_pkt_cnt = '1;
    tick();
    release dut.r_pkt_cnt;
    #1;
    check_val("t6_preload", 512'(pkt_of(0)), 512'({CNT_W{1'b1}}));
    push_pkt(0, 5, 2);
    drive_inputs();
    drain(20);
    check_val("t6_wrap0", 512'(pkt_of(0)), 512'(0));
    check_val("t6_hold1", 512'(pkt_of(1)), 512'({CNT_W{1'b1}}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
